// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART RX engine and the register bus.
// Stores each received character with its {break, framing, parity} status in a
// DEPTH-entry FIFO and offers a valid/ready dequeue port. It also produces the
// watermark, error-at-head and sticky overrun status for interrupt logic.
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to add io_div / io_ip_timeout,
// an idle-character timeout that fires after 4 character times with data pending.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          io_in_valid,
    input  logic [7:0]    io_in_bits,
    input  logic [2:0]    io_in_err,
    input  logic          io_deq_ready,
    output logic          io_deq_valid,
    output logic [7:0]    io_deq_bits,
    output logic [2:0]    io_deq_err,
    output logic [AW:0]   io_count,
    input  logic [AW:0]   io_rxwm,
    output logic          io_ip_rxwm,
    output logic          io_ip_err,
    output logic          io_overrun,
    input  logic          io_clr_overrun,
`ifdef UART_RX_FIFO_TIMEOUT_EN
    input  logic [15:0]   io_div,
    output logic          io_ip_timeout,
`endif
    input  logic          io_flush
);

    // Storage entry layout: {err[2:0], bits[7:0]}
    logic [10:0]  r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         r_overrun;

    logic [AW:0]  w_count;
    logic         w_empty;
    logic         w_full;
    logic         w_push;
    logic         w_pop;
    logic         w_drop;
    logic [10:0]  w_head;

    // Occupancy and push/pop qualification derived from the pointer pair
    always_comb begin
        w_count = r_wr_ptr - r_rd_ptr;
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop   = !w_empty && io_deq_ready;
        w_push  = io_in_valid && (!w_full || w_pop);
        w_drop  = io_in_valid && w_full && !w_pop;
        w_head  = r_mem[r_rd_ptr[AW-1:0]];
    end

    // Character storage; deliberately not reset, contents only meaningful when non-empty
    always_ff @(posedge clock) begin
        if (w_push && !io_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {io_in_err, io_in_bits};
        end
    end

    // Pointer update; flush has priority over any same-cycle push or pop
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (io_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear still sets the flag
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (io_flush) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (io_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Dequeue port and interrupt status, all from registered state
    always_comb begin
        io_deq_valid = !w_empty;
        io_deq_bits  = w_head[7:0];
        io_deq_err   = w_head[10:8];
        io_count     = w_count;
        io_ip_rxwm   = (w_count > io_rxwm);
        io_ip_err    = !w_empty && (|w_head[10:8]);
        io_overrun   = r_overrun;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0]  r_baud_cnt;
    logic [5:0]   r_bit_cnt;
    logic         r_ip_timeout;
    logic         w_activity;
    logic         w_run;

    // Any push, pop or flush restarts the idle measurement
    always_comb begin
        w_activity = w_push || w_pop || io_flush;
        w_run      = !w_empty && !w_activity && (io_div != 16'd0);
    end

    // Idle timer: baud counter divides down to bit times, bit counter counts to 40
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_ip_timeout <= 1'b0;
        end else if (w_activity || io_div == 16'd0) begin
            r_baud_cnt   <= io_div - 16'd1;
            r_bit_cnt    <= '0;
            r_ip_timeout <= 1'b0;
        end else if (w_run) begin
            if (r_baud_cnt == 16'd0) begin
                r_baud_cnt <= io_div - 16'd1;
                if (r_bit_cnt != 6'd40) begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (r_bit_cnt == 6'd39) r_ip_timeout <= 1'b1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
            end
        end
    end

    assign io_ip_timeout = r_ip_timeout;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

    logic        clock;
    logic        rst_n;
    logic        io_in_valid;
    logic [7:0]  io_in_bits;
    logic [2:0]  io_in_err;
    logic        io_deq_ready;
    logic        io_deq_valid;
    logic [7:0]  io_deq_bits;
    logic [2:0]  io_deq_err;
    logic [4:0]  io_count;
    logic [4:0]  io_rxwm;
    logic        io_ip_rxwm;
    logic        io_ip_err;
    logic        io_overrun;
    logic        io_clr_overrun;
    logic        io_flush;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0] io_div;
    logic        io_ip_timeout;
`endif

    int checks = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .io_in_valid    (io_in_valid),
        .io_in_bits     (io_in_bits),
        .io_in_err      (io_in_err),
        .io_deq_ready   (io_deq_ready),
        .io_deq_valid   (io_deq_valid),
        .io_deq_bits    (io_deq_bits),
        .io_deq_err     (io_deq_err),
        .io_count       (io_count),
        .io_rxwm        (io_rxwm),
        .io_ip_rxwm     (io_ip_rxwm),
        .io_ip_err      (io_ip_err),
        .io_overrun     (io_overrun),
        .io_clr_overrun (io_clr_overrun),
`ifdef UART_RX_FIFO_TIMEOUT_EN
        .io_div         (io_div),
        .io_ip_timeout  (io_ip_timeout),
`endif
        .io_flush       (io_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic [2:0] e);
        io_in_valid = 1'b1;
        io_in_bits  = b;
        io_in_err   = e;
        tick();
        io_in_valid = 1'b0;
        io_in_err   = 3'b000;
    endtask

    task automatic pop();
        io_deq_ready = 1'b1;
        tick();
        io_deq_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        io_in_valid = 1'b0; io_in_bits = 8'h00; io_in_err = 3'b000;
        io_deq_ready = 1'b0; io_rxwm = 5'd0; io_clr_overrun = 1'b0; io_flush = 1'b0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        io_div = 16'd0;
`endif
        #22;
        checks++; if (io_deq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", io_deq_valid); end
        checks++; if (io_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", io_count); end
        checks++; if (io_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", io_overrun); end
        checks++; if (io_ip_rxwm !== 1'b0 || io_ip_err !== 1'b0) begin failures++; $display("FAIL reset_ip got=%b%b exp=00", io_ip_rxwm, io_ip_err); end
`ifdef UART_RX_FIFO_TIMEOUT_EN
        checks++; if (io_ip_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", io_ip_timeout); end
`endif
        @(negedge clock);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push(8'h41, 3'b000);
        checks++; if (io_deq_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", io_deq_valid); end
        checks++; if (io_deq_bits !== 8'h41) begin failures++; $display("FAIL single_bits got=%h exp=41", io_deq_bits); end
        checks++; if (io_count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", io_count); end
        pop();
        checks++; if (io_count !== 5'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", io_count); end
        checks++; if (io_deq_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", io_deq_valid); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 17; i++) push(8'(i), 3'b000);
        checks++; if (io_count !== 5'd16) begin failures++; $display("FAIL ovr_count got=%0d exp=16", io_count); end
        checks++; if (io_overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", io_overrun); end
        // drop and clear in the same cycle: set wins
        io_clr_overrun = 1'b1;
        push(8'h99, 3'b000);
        checks++; if (io_overrun !== 1'b1) begin failures++; $display("FAIL ovr_setwins got=%b exp=1", io_overrun); end
        tick();
        io_clr_overrun = 1'b0;
        checks++; if (io_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", io_overrun); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (io_deq_bits !== 8'(i)) begin failures++; $display("FAIL ovr_order[%0d] got=%h exp=%h", i, io_deq_bits, 8'(i)); end
            pop();
        end
        checks++; if (io_count !== 5'd0) begin failures++; $display("FAIL ovr_drain got=%0d exp=0", io_count); end
        pop();
        checks++; if (io_count !== 5'd0 || io_deq_valid !== 1'b0) begin failures++; $display("FAIL empty_pop got=%0d/%b exp=0/0", io_count, io_deq_valid); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 3'b000);
        io_deq_ready = 1'b1;
        push(8'hAA, 3'b000);
        io_deq_ready = 1'b0;
        checks++; if (io_count !== 5'd16) begin failures++; $display("FAIL fpp_count got=%0d exp=16", io_count); end
        checks++; if (io_overrun !== 1'b0) begin failures++; $display("FAIL fpp_overrun got=%b exp=0", io_overrun); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp;
            exp = (i == 15) ? 8'hAA : 8'h21 + 8'(i);
            checks++; if (io_deq_bits !== exp) begin failures++; $display("FAIL fpp_order[%0d] got=%h exp=%h", i, io_deq_bits, exp); end
            pop();
        end
    endtask

    task automatic test_err();
        push(8'h55, 3'b010);
        push(8'h66, 3'b000);
        checks++; if (io_ip_err !== 1'b1) begin failures++; $display("FAIL err_ip got=%b exp=1", io_ip_err); end
        checks++; if (io_deq_err !== 3'b010) begin failures++; $display("FAIL err_bits got=%b exp=010", io_deq_err); end
        pop();
        checks++; if (io_ip_err !== 1'b0) begin failures++; $display("FAIL err_clean got=%b exp=0", io_ip_err); end
        checks++; if (io_deq_bits !== 8'h66) begin failures++; $display("FAIL err_next got=%h exp=66", io_deq_bits); end
        pop();
    endtask

    task automatic test_watermark_flush();
        io_rxwm = 5'd3;
        for (int i = 0; i < 3; i++) push(8'h30 + 8'(i), 3'b000);
        checks++; if (io_ip_rxwm !== 1'b0) begin failures++; $display("FAIL wm_at3 got=%b exp=0", io_ip_rxwm); end
        push(8'h33, 3'b000);
        checks++; if (io_ip_rxwm !== 1'b1) begin failures++; $display("FAIL wm_at4 got=%b exp=1", io_ip_rxwm); end
        for (int i = 0; i < 13; i++) push(8'h40 + 8'(i), 3'b000);
        checks++; if (io_overrun !== 1'b1) begin failures++; $display("FAIL wm_ovr got=%b exp=1", io_overrun); end
        // flush outranks a same-cycle push and pop
        io_flush = 1'b1;
        io_deq_ready = 1'b1;
        push(8'hEE, 3'b001);
        io_flush = 1'b0;
        io_deq_ready = 1'b0;
        checks++; if (io_count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", io_count); end
        checks++; if (io_ip_rxwm !== 1'b0) begin failures++; $display("FAIL flush_wm got=%b exp=0", io_ip_rxwm); end
        checks++; if (io_overrun !== 1'b0) begin failures++; $display("FAIL flush_ovr got=%b exp=0", io_overrun); end
        checks++; if (io_deq_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", io_deq_valid); end
        io_rxwm = 5'd0;
        push(8'h77, 3'b000);
        checks++; if (io_deq_bits !== 8'h77 || io_count !== 5'd1) begin failures++; $display("FAIL post_flush got=%h/%0d exp=77/1", io_deq_bits, io_count); end
        pop();
    endtask

    task automatic test_async_reset();
        push(8'h01, 3'b000);
        push(8'h02, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (io_count !== 5'd0 || io_deq_valid !== 1'b0) begin failures++; $display("FAIL async_rst got=%0d/%b exp=0/0", io_count, io_deq_valid); end
        @(negedge clock);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef UART_RX_FIFO_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        io_div = 16'd4;
        push(8'h5A, 3'b000);
        n = 0;
        while (io_ip_timeout !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (n < 158 || n > 162) begin failures++; $display("FAIL timeout_cycles got=%0d exp=160", n); end
        pop();
        checks++; if (io_ip_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", io_ip_timeout); end
        io_div = 16'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_full_push_pop();
        test_err();
        test_watermark_flush();
`ifdef UART_RX_FIFO_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
